// File: rtl/goertzel_frame_ctrl_if.sv
// Control/status bundle between the register block, the Goertzel datapath and goertzel_frame_ctrl.
// master = register/datapath side, slave = the frame controller.
interface goertzel_frame_ctrl_if #(
  parameter int NF   = 11,
  parameter int CNTW = 16
);
  logic            start_i;
  logic            abort_i;
  logic            cont_i;
  logic            coef_req_o;
  logic            coef_valid_i;
  logic            smp_stb_i;
  logic            smp_en_o;
  logic [NF-1:0]   bin_valid_i;
  logic            busy_o;
  logic            done_o;
  logic            err_to_o;
  logic            ovr_o;
  logic [CNTW-1:0] smp_cnt_o;
  logic [15:0]     frame_cnt_o;
  logic [2:0]      state_o;

  modport master (
    output start_i, abort_i, cont_i, coef_valid_i, smp_stb_i, bin_valid_i,
    input  coef_req_o, smp_en_o, busy_o, done_o, err_to_o, ovr_o,
           smp_cnt_o, frame_cnt_o, state_o
  );

  modport slave (
    input  start_i, abort_i, cont_i, coef_valid_i, smp_stb_i, bin_valid_i,
    output coef_req_o, smp_en_o, busy_o, done_o, err_to_o, ovr_o,
           smp_cnt_o, frame_cnt_o, state_o
  );
endinterface

// File: rtl/goertzel_frame_ctrl.sv
// Goertzel frame sequencer: coefficient request, NS-sample gating, per-bin drain, frame completion.
// Optional overrun detection is compiled in with `define GFC_OVERRUN_DET_EN.

// One bit of the drain completion mask.
module gfc_bin_lane (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  input  logic bin_valid,
  output logic mask_q,
  output logic mask_n
);
  assign mask_n = mask_q | (en & bin_valid);

  always_ff @(posedge clk) begin
    if (!rstn)    mask_q <= 1'b0;
    else if (clr) mask_q <= 1'b0;
    else          mask_q <= mask_n;
  end
endmodule

module goertzel_frame_ctrl #(
  parameter int NF       = 11,
  parameter int NS       = 1000,
  parameter int CNTW     = 16,
  parameter int DRAIN_TO = 64
) (
  input logic                  clk,
  input logic                  rstn,
  goertzel_frame_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] COEF_REQ  = 3'd1;
  localparam logic [2:0] COEF_WAIT = 3'd2;
  localparam logic [2:0] ACQ       = 3'd3;
  localparam logic [2:0] DRAIN     = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;

  localparam int            DW         = (DRAIN_TO > 1) ? $clog2(DRAIN_TO) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TO - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(NS - 1);

  logic [2:0]      state, nxt;
  logic            acc, clr_frame, drain_hit, start_ok;
  logic [NF-1:0]   mask_q, mask_n;
  logic [DW-1:0]   drain_cnt;
  logic [CNTW-1:0] smp_cnt;
  logic [15:0]     frame_cnt;
  logic            coef_req_r, smp_en_r, busy_r, done_r, err_r;
  logic [2:0]      state_r;

  genvar g;
  generate
    for (g = 0; g < NF; g++) begin : g_lane
      gfc_bin_lane u_lane (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (clr_frame),
        .en       (state == DRAIN),
        .bin_valid(bus.bin_valid_i[g]),
        .mask_q   (mask_q[g]),
        .mask_n   (mask_n[g])
      );
    end
  endgenerate

  assign start_ok = (state == IDLE) && bus.start_i && !bus.abort_i;

  always_comb begin
    nxt       = state;
    acc       = 1'b0;
    clr_frame = 1'b0;
    drain_hit = 1'b0;
    case (state)
      IDLE:      if (bus.start_i) nxt = COEF_REQ;
      COEF_REQ:  nxt = COEF_WAIT;
      COEF_WAIT: if (bus.coef_valid_i) begin
                   nxt       = ACQ;
                   clr_frame = 1'b1;
                 end
      ACQ:       if (bus.smp_stb_i && bus.coef_valid_i) begin
                   acc = 1'b1;
                   if (smp_cnt == CNT_LAST) nxt = DRAIN;
                 end
      // mask_n already folds in this cycle's bin_valid, so completion wins over timeout
      DRAIN:     if (&mask_n) nxt = DONE;
                 else if (drain_cnt == DRAIN_LAST) begin
                   nxt       = DONE;
                   drain_hit = 1'b1;
                 end
      DONE:      if (bus.cont_i) begin
                   nxt       = ACQ;
                   clr_frame = 1'b1;
                 end else nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (bus.abort_i) begin
      nxt       = IDLE;
      acc       = 1'b0;
      clr_frame = 1'b0;
      drain_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      state_r    <= IDLE;
      coef_req_r <= 1'b0;
      smp_en_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      smp_cnt    <= '0;
      frame_cnt  <= '0;
      drain_cnt  <= '0;
    end else begin
      state      <= nxt;
      state_r    <= nxt;
      coef_req_r <= (nxt == COEF_REQ);
      busy_r     <= (nxt != IDLE);
      done_r     <= (nxt == DONE);
      smp_en_r   <= acc;
      drain_cnt  <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
      if (clr_frame)  smp_cnt <= '0;
      else if (acc)   smp_cnt <= smp_cnt + CNTW'(1);
      if (nxt == DONE) frame_cnt <= frame_cnt + 16'd1;
      if (start_ok)       err_r <= 1'b0;
      else if (drain_hit) err_r <= 1'b1;
    end
  end

`ifdef GFC_OVERRUN_DET_EN
  logic ovr_r;
  logic ovr_hit;
  // a strobe the datapath cannot take: before coefficients, or between frames when back-to-back
  assign ovr_hit = bus.smp_stb_i && !bus.abort_i &&
                   ((state == COEF_WAIT) ||
                    (bus.cont_i && ((state == DRAIN) || (state == DONE))));

  always_ff @(posedge clk) begin
    if (!rstn)         ovr_r <= 1'b0;
    else if (start_ok) ovr_r <= 1'b0;
    else if (ovr_hit)  ovr_r <= 1'b1;
  end
  assign bus.ovr_o = ovr_r;
`else
  assign bus.ovr_o = 1'b0;
`endif

  assign bus.state_o     = state_r;
  assign bus.coef_req_o  = coef_req_r;
  assign bus.smp_en_o    = smp_en_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;
  assign bus.err_to_o    = err_r;
  assign bus.smp_cnt_o   = smp_cnt;
  assign bus.frame_cnt_o = frame_cnt;
endmodule

// File: tb/tb_goertzel_frame_ctrl.sv
// Directed bench for goertzel_frame_ctrl (NS=8, NF=2) with sample/frame scoreboards.
module tb_goertzel_frame_ctrl;
  localparam int NF = 2, NS = 8, CNTW = 16, DRAIN_TO = 16;

  logic clk, rstn;
  goertzel_frame_ctrl_if #(.NF(NF), .CNTW(CNTW)) bus ();

  goertzel_frame_ctrl #(.NF(NF), .NS(NS), .CNTW(CNTW), .DRAIN_TO(DRAIN_TO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int en_cnt = 0, done_cnt = 0, req_cnt = 0, coef_seen = 0;
  int exp_smp = 0, exp_frame = 0;
  bit acq_m = 0;
  int sb_q[$];
  int done_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // sample-accept model: a strobe with coef valid while the bench expects ACQ
  task automatic drive(input logic stb, input logic cv, input logic [NF-1:0] bv);
    bus.smp_stb_i    = stb;
    bus.coef_valid_i = cv;
    bus.bin_valid_i  = bv;
    if (stb && cv && acq_m) begin
      exp_smp++;
      sb_q.push_back(exp_smp);
      if (exp_smp == NS) acq_m = 0;
    end
    step();
    bus.smp_stb_i   = 1'b0;
    bus.bin_valid_i = '0;
  endtask

  task automatic expect_done();
    exp_frame++;
    done_q.push_back(exp_frame);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.start_i = 0; bus.abort_i = 0; bus.cont_i = 0;
    bus.coef_valid_i = 0; bus.smp_stb_i = 0; bus.bin_valid_i = '0;
    repeat (3) step();
    rstn = 1'b1;
    sb_q.delete(); done_q.delete();
    exp_frame = 0; exp_smp = 0; acq_m = 0;
    step();
  endtask

  task automatic start_frame();
    bus.coef_valid_i = 1'b0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    chk("req_state", 32'(bus.state_o), 1);
    chk("req_pulse", 32'(bus.coef_req_o), 1);
    step(); step(); step();
    chk("wait_state", 32'(bus.state_o), 2);
    bus.coef_valid_i = 1'b1;
    step();
    chk("acq_entry", 32'(bus.state_o), 3);
    acq_m = 1; exp_smp = 0;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (bus.smp_en_o) begin
        en_cnt++;
        if (sb_q.size() == 0) chk("smp_en_unexpected", 1, 0);
        else chk("smp_cnt_at_en", 32'(bus.smp_cnt_o), 32'(sb_q.pop_front()));
      end
      if (bus.done_o) begin
        done_cnt++;
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else chk("frame_cnt_at_done", 32'(bus.frame_cnt_o), 32'(done_q.pop_front()));
      end
      if (bus.coef_req_o) req_cnt++;
      if (bus.state_o == 3'd1 || bus.state_o == 3'd2) coef_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ovr_exp;
    do_reset();
    chk("rst_state", 32'(bus.state_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    chk("rst_smp_cnt", 32'(bus.smp_cnt_o), 0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt_o), 0);
    chk("rst_flags", {28'd0, bus.err_to_o, bus.ovr_o, bus.done_o, bus.smp_en_o}, 0);

    // 1: single frame, strobe every cycle
    en_cnt = 0; done_cnt = 0; req_cnt = 0;
    start_frame();
    chk("t1_busy", 32'(bus.busy_o), 1);
    for (int i = 0; i < 20 && acq_m; i++) drive(1, 1, '0);
    chk("t1_drain_state", 32'(bus.state_o), 4);
    chk("t1_drain_cnt", 32'(bus.smp_cnt_o), NS);
    drive(0, 1, '0);
    expect_done();
    drive(0, 1, 2'b11);
    chk("t1_done_state", 32'(bus.state_o), 5);
    drive(0, 1, '0);
    chk("t1_idle", 32'(bus.state_o), 0);
    chk("t1_busy_low", 32'(bus.busy_o), 0);
    chk("t1_cnt_hold", 32'(bus.smp_cnt_o), NS);
    chk("t1_en_pulses", en_cnt, NS);
    chk("t1_done_pulses", done_cnt, 1);
    chk("t1_req_pulses", req_cnt, 1);

    // 2: sparse strobes with a coef_valid gap
    en_cnt = 0;
    start_frame();
    for (int i = 0; i < 300 && acq_m; i++) drive((i % 3) == 0, !(i >= 7 && i < 11), '0);
    chk("t2_drain_state", 32'(bus.state_o), 4);
    chk("t2_drain_cnt", 32'(bus.smp_cnt_o), NS);
    drive(0, 1, 2'b01);
    expect_done();
    drive(0, 1, 2'b10);
    chk("t2_done_state", 32'(bus.state_o), 5);
    drive(0, 1, '0);
    chk("t2_idle", 32'(bus.state_o), 0);
    chk("t2_en_pulses", en_cnt, NS);

    // 3: continuous mode, 3 frames
    do_reset();
    done_cnt = 0; req_cnt = 0;
    bus.cont_i = 1'b1;
    start_frame();
    coef_seen = 0;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 20 && acq_m; i++) drive(1, 1, '0);
      chk("t3_drain_state", 32'(bus.state_o), 4);
      expect_done();
      if (f == 2) bus.cont_i = 1'b0;
      drive(0, 1, 2'b11);
      chk("t3_done_state", 32'(bus.state_o), 5);
      drive(0, 1, '0);
      if (f < 2) begin
        chk("t3_reacq", 32'(bus.state_o), 3);
        chk("t3_cnt_clr", 32'(bus.smp_cnt_o), 0);
        acq_m = 1; exp_smp = 0;
      end else chk("t3_idle", 32'(bus.state_o), 0);
    end
    chk("t3_req_pulses", req_cnt, 1);
    chk("t3_done_pulses", done_cnt, 3);
    chk("t3_frame_cnt", 32'(bus.frame_cnt_o), 3);
    chk("t3_no_coef_states", coef_seen, 0);

    // 4: bin 1 withheld -> drain timeout
    start_frame();
    for (int i = 0; i < 20 && acq_m; i++) drive(1, 1, '0);
    chk("t4_drain_state", 32'(bus.state_o), 4);
    for (int i = 0; i < DRAIN_TO - 1; i++) drive(0, 1, 2'b01);
    chk("t4_err_early", 32'(bus.err_to_o), 0);
    chk("t4_still_drain", 32'(bus.state_o), 4);
    expect_done();
    drive(0, 1, 2'b01);
    chk("t4_err_set", 32'(bus.err_to_o), 1);
    chk("t4_done_state", 32'(bus.state_o), 5);
    drive(0, 1, '0);
    chk("t4_err_sticky", 32'(bus.err_to_o), 1);
    start_frame();
    chk("t4_err_clr", 32'(bus.err_to_o), 0);

    // 5: abort at sample 4
    for (int i = 0; i < 3; i++) drive(1, 1, '0);
    bus.abort_i = 1'b1; bus.smp_stb_i = 1'b1;
    step();
    bus.abort_i = 1'b0; bus.smp_stb_i = 1'b0; acq_m = 0;
    chk("t5_idle", 32'(bus.state_o), 0);
    chk("t5_smp_en", 32'(bus.smp_en_o), 0);
    chk("t5_no_done", 32'(bus.done_o), 0);
    chk("t5_frame_cnt", 32'(bus.frame_cnt_o), exp_frame);
    drive(1, 1, '0);
    drive(1, 1, '0);
    chk("t5_smp_en_after", 32'(bus.smp_en_o), 0);
    bus.start_i = 1'b1; bus.abort_i = 1'b1;
    step();
    bus.start_i = 1'b0; bus.abort_i = 1'b0;
    chk("t5_start_abort_idle", 32'(bus.state_o), 0);
    chk("t5_start_abort_req", 32'(bus.coef_req_o), 0);
    step();
    chk("t5_stay_idle", 32'(bus.busy_o), 0);

    // 6: strobe during DRAIN in continuous mode
`ifdef GFC_OVERRUN_DET_EN
    ovr_exp = 1'b1;
`else
    ovr_exp = 1'b0;
`endif
    bus.cont_i = 1'b1;
    start_frame();
    for (int i = 0; i < 20 && acq_m; i++) drive(1, 1, '0);
    chk("t6_ovr_before", 32'(bus.ovr_o), 0);
    drive(1, 1, '0);
    chk("t6_ovr", 32'(bus.ovr_o), 32'(ovr_exp));
    expect_done();
    drive(0, 1, 2'b11);
    bus.cont_i = 1'b0;
    drive(0, 1, '0);
    chk("t6_idle", 32'(bus.state_o), 0);
    chk("t6_ovr_sticky", 32'(bus.ovr_o), 32'(ovr_exp));
    start_frame();
    chk("t6_ovr_clr", 32'(bus.ovr_o), 0);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0; acq_m = 0;
    step();
    chk("sb_empty", sb_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/goertzel_frame_ctrl.md
Name: goertzel_frame_ctrl

Overview:
- Frame sequencer for the Goertzel analysis chain.
- On a register-issued start it requests coefficient generation (angle/CORDIC stage) and waits for coefficients.
- It then gates exactly NS sample strobes into the scaling/filter datapath, collects per-bin completion from the NF filter instances, and reports frame completion.
- Sits between the register block and the Angel/Cordic/DataScale/Herzel pipeline; supports single-shot and continuous frames.

Parameters:
NF, 11, number of frequency bins (filter instances)
NS, 1000, samples per frame
CNTW, 16, width of sample counter (must satisfy 2^CNTW > NS)
DRAIN_TO, 64, max cycles to wait for all bin_valid after last sample

Ports:
clk  in  1  system clock
rstn  in  1  synchronous active-low reset
start_i  in  1  one-cycle start pulse from register block
abort_i  in  1  one-cycle abort pulse
cont_i  in  1  continuous mode: restart acquisition after each frame
coef_req_o  out  1  one-cycle coefficient-generation request
coef_valid_i  in  1  coefficients valid (level)
smp_stb_i  in  1  raw sample strobe (enable input)
smp_en_o  out  1  gated sample strobe to scaling stage
bin_valid_i  in  NF  per-bin result-valid pulses/levels
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle frame-complete pulse
err_to_o  out  1  sticky drain-timeout flag
ovr_o  out  1  sticky overrun flag (see Optional Feature)
smp_cnt_o  out  CNTW  samples accepted in current frame
frame_cnt_o  out  16  completed frames since reset, wraps 0xFFFF->0
state_o  out  3  encoded state for debug readback

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low on rstn; every register changes only on clk rising edge.
- Reset values: all outputs 0, state IDLE, bin mask 0.
- All outputs are registered.
- States (state_o encoding): IDLE=0, COEF_REQ=1, COEF_WAIT=2, ACQ=3, DRAIN=4, DONE=5.
- IDLE:
  - start_i -> COEF_REQ.
  - start_i is ignored in every other state.
- COEF_REQ:
  - coef_req_o=1 for exactly this cycle.
  - -> COEF_WAIT unconditionally.
- COEF_WAIT:
  - When coef_valid_i=1: clear smp_cnt and bin mask -> ACQ.
  - No timeout.
- ACQ:
  - Each cycle with smp_stb_i=1 and coef_valid_i=1: smp_en_o=1 the following cycle (latency 1); smp_cnt increments.
  - The strobe that makes smp_cnt==NS is the last accepted one -> DRAIN.
  - Strobes in ACQ with coef_valid_i=0 are dropped and not counted.
- DRAIN:
  - mask |= bin_valid_i each cycle.
  - The drain counter counts from 0.
  - When mask is all ones (including bits set this cycle) -> DONE.
  - If the counter reaches DRAIN_TO-1 first: set err_to_o -> DONE.
  - smp_en_o is held 0.
- DONE:
  - done_o=1 for this cycle; frame_cnt increments.
  - cont_i=1 -> ACQ directly, reusing coefficients; smp_cnt and mask are cleared.
  - cont_i=0 -> IDLE.
- smp_cnt_o holds its final value (NS) in IDLE until the next frame starts.
- abort_i:
  - Has priority over every other event in every state.
  - Next state is IDLE; smp_en_o=0 next cycle.
  - No done_o and no frame_cnt increment; sticky flags are retained.
- err_to_o and ovr_o clear only on reset or on start_i accepted in IDLE.
- abort_i and start_i in the same cycle in IDLE: remain IDLE.

Optional Feature:
- GFC_OVERRUN_DET_EN defined:
  - ovr_o sets when smp_stb_i=1 arrives in DRAIN or DONE while cont_i=1. The sample is lost.
  - Also sets when smp_stb_i=1 arrives in COEF_WAIT.
- Not defined: ovr_o is constant 0; the detection logic is absent.

Test Plan:
1. Single frame with NS=8, NF=2. Stimulus: start pulse, coef_valid high 3 cycles later, strobe every cycle, bin_valid=2'b11 two cycles after the 8th strobe. Required: coef_req one cycle; smp_en_o exactly 8 pulses; done_o one pulse; frame_cnt_o=1; state returns to 0.
2. Strobe every 3rd cycle with coef_valid dropped for 4 cycles mid-frame. Required: strobes during the gap are not counted; smp_cnt_o=NS at DRAIN entry; smp_en_o count = NS.
3. Continuous mode, 3 frames. Required: a single coef_req_o; done_o 3 times; frame_cnt_o=3; COEF states not re-entered.
4. bin_valid bit 1 withheld. Required: err_to_o=1 exactly DRAIN_TO cycles after DRAIN entry; done_o still pulses; err_to_o clears on the next start.
5. abort_i at sample 4 of 8. Required: IDLE next cycle; no done_o; frame_cnt_o unchanged; smp_en_o=0 afterward. Second case: start_i and abort_i together in IDLE -> stays IDLE.
6. With GFC_OVERRUN_DET_EN defined, a strobe during DRAIN in continuous mode -> ovr_o=1. Without the macro -> ovr_o=0.
